// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage with hold/flush control from the pipeline controller.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build (registered in_ready); default is one entry.
module pipe_stage_hs #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0,
    parameter logic [DW-1:0] NOP_VAL = DW'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          hold_i,
    input  logic          flush_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ_o
);

    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] out_q, out_d;
    logic          out_vld_reg;
    logic          in_fire, out_fire;

    assign out_vld_reg = (occ_q != 2'd0);
    // hold and flush both hide the stage from downstream for the cycle
    assign out_valid   = out_vld_reg && !hold_i && !flush_i;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign out_data    = out_q;
    assign occ_o       = occ_q;

`ifdef PIPE_STAGE_SKID_EN
    logic [DW-1:0] skid_q, skid_d;
    logic          rdy_q;

    // rdy_q only depends on occupancy, so out_ready never reaches in_ready
    assign in_ready = rdy_q && !hold_i && !flush_i && !rst;

    always_comb begin
        occ_d  = occ_q;
        out_d  = out_q;
        skid_d = skid_q;
        if (flush_i) begin
            occ_d = 2'd0;
            out_d = NOP_VAL;
        end else begin
            case ({in_fire, out_fire})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        out_d = in_data;
                        occ_d = 2'd1;
                    end else begin
                        skid_d = in_data;
                        occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    if (occ_q == 2'd2) begin
                        out_d = skid_q;
                        occ_d = 2'd1;
                    end else begin
                        out_d = NOP_VAL;
                        occ_d = 2'd0;
                    end
                end
                // in_ready is low at occ 2, so a dual transfer always happens at occ 1
                2'b11:   out_d = in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            out_q  <= RST_VAL;
            skid_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            occ_q  <= occ_d;
            out_q  <= out_d;
            skid_q <= skid_d;
            rdy_q  <= (occ_d != 2'd2);
        end
    end
`else
    assign in_ready = (!out_vld_reg || out_ready) && !hold_i && !flush_i && !rst;

    always_comb begin
        occ_d = occ_q;
        out_d = out_q;
        if (flush_i) begin
            occ_d = 2'd0;
            out_d = NOP_VAL;
        end else if (in_fire) begin
            out_d = in_data;
            occ_d = 2'd1;
        end else if (out_fire) begin
            out_d = NOP_VAL;
            occ_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            out_q <= RST_VAL;
        end else begin
            occ_q <= occ_d;
            out_q <= out_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: scoreboard on the output stream plus direct state checks.
// Expectations follow PIPE_STAGE_SKID_EN when it is defined for the build.
module tb_pipe_stage_hs;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, hold_i, flush_i, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occ_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .hold_i   (hold_i),
        .flush_i  (flush_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occ_o    (occ_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: accepted payloads queue up, delivered payloads must match in order
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got %h with no payload outstanding", out_data);
                end else begin
                    chk("sb_order", out_data, exp_q.pop_front());
                end
            end
            if (flush_i)
                exp_q.delete();
            else if (in_valid && in_ready && !hold_i)
                exp_q.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
            step();
        end
        if (k == 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: in_ready stayed low for 20 cycles", nm);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        out_ready = 1'b1; hold_i = 1'b0; flush_i = 1'b0;

        // reset with a payload offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_occ", 32'(occ_o), 0);
        step();
        rst = 1'b0;

        // streaming 1..4, first offer right after release
        for (int d = 1; d <= 4; d++) begin
            in_valid = 1'b1; in_data = d;
            @(negedge clk);
            if (d == 1) begin
                chk("rel_in_ready", 32'(in_ready), 1);
                chk("rel_out_data", out_data, 32'h0);
                chk("rel_occ", 32'(occ_o), 0);
            end else begin
                chk("stream_valid", 32'(out_valid), 1);
                chk("stream_data", out_data, d - 1);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last", out_data, 32'd4);
        chk("stream_occ", 32'(occ_o), 1);
        step();
        @(negedge clk);
        chk("drain_occ", 32'(occ_o), 0);
        chk("drain_nop", out_data, NOP);
        chk("drain_valid", 32'(out_valid), 0);

        // backpressure
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
        step();
        in_data = 32'd2;
`ifdef PIPE_STAGE_SKID_EN
        @(negedge clk);
        chk("bp_acc2", 32'(in_ready), 1);
        step();
        in_data = 32'd3;
        @(negedge clk);
        chk("bp_occ", 32'(occ_o), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_head", out_data, 32'd1);
        step();
        @(negedge clk);
        chk("bp_frozen", 32'(occ_o), 2);
        chk("bp_valid", 32'(out_valid), 1);
        step();
        out_ready = 1'b1;
        wait_accept("bp_3");
`else
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_occ", 32'(occ_o), 1);
        chk("bp_head", out_data, 32'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("ns_comb_ready", 32'(in_ready), 1);
        step();
        in_data = 32'd3;
        @(negedge clk);
        chk("ns_occ", 32'(occ_o), 1);
        chk("ns_data", out_data, 32'd2);
        step();
`endif
        in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("bp_drain", 32'(occ_o), 0);

        // hold with one entry buffered and payload 5 waiting
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        wait_accept("hold_pre");
        in_data = 32'd5; hold_i = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_valid", 32'(out_valid), 0);
            chk("hold_occ", 32'(occ_o), 1);
            chk("hold_data", out_data, 32'd7);
            step();
        end
        hold_i = 1'b0;
        wait_accept("hold_rel");
        in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("hold_drain", 32'(occ_o), 0);

        // flush and hold together with payload 9 offered
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        wait_accept("fl_a");
`ifdef PIPE_STAGE_SKID_EN
        in_data = 32'hB;
        wait_accept("fl_b");
`endif
        in_data = 32'd9; flush_i = 1'b1; hold_i = 1'b1;
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        chk("fl_pre_occ", 32'(occ_o), 2);
`else
        chk("fl_pre_occ", 32'(occ_o), 1);
`endif
        chk("fl_in_ready", 32'(in_ready), 0);
        chk("fl_out_valid", 32'(out_valid), 0);
        step();
        flush_i = 1'b0; hold_i = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_occ", 32'(occ_o), 0);
        chk("fl_nop", out_data, NOP);
        chk("fl_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("fl_empty", 32'(out_valid), 0);

        // stage still usable after flush
        step();
        in_valid = 1'b1; in_data = 32'h55;
        wait_accept("post_fl");
        in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("post_occ", 32'(occ_o), 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 Parameter DW, default 32, payload width in bits (1..256).
REQ-002 Parameter RST_VAL, default 0, out_data value held after reset.
REQ-003 Parameter NOP_VAL, default 32'h00000013, out_data value when the stage is empty after flush or drain; width DW.
REQ-004 Port clk  input  1  rising-edge clock; the block uses one clock.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port in_valid  input  1  upstream payload valid.
REQ-007 Port in_ready  output  1  stage can accept the payload this cycle.
REQ-008 Port in_data  input  DW  upstream payload (inst, addr, operands, rd, wen packed by the parent).
REQ-009 Port hold_i  input  1  stall request from ctrl.
REQ-010 Port flush_i  input  1  kill request from ctrl (branch/jump/trap).
REQ-011 Port out_valid  output  1  downstream payload valid.
REQ-012 Port out_ready  input  1  downstream can accept.
REQ-013 Port out_data  output  DW  downstream payload.
REQ-014 Port occ_o  output  2  number of buffered entries (0..2).

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready; both SHALL be evaluated on the same rising edge.
REQ-016 The latency from an input transfer to out_valid SHALL be exactly one cycle when the stage is empty.
REQ-017 Payloads SHALL leave the stage in arrival order, with no duplication or loss except by flush.
REQ-018 out_data SHALL show the oldest entry while out_valid=1, and SHALL show NOP_VAL while occ_o=0 (RST_VAL until the first transfer after reset).
REQ-019 While hold_i=1, in_ready and out_valid SHALL be 0, and the entries and occ_o SHALL stay frozen.
REQ-020 flush_i=1 SHALL take priority over hold_i and all transfers: in_ready=0 in that cycle, so no input is accepted; on the next edge occ_o=0, out_valid=0 and out_data=NOP_VAL.
REQ-021 A simultaneous input transfer and output transfer at occ_o=1 SHALL leave occ_o=1 with the new payload at the output.
REQ-022 An output transfer with no input SHALL decrement occ_o; when occ_o=2 the second entry SHALL move to the output register in the same edge.
REQ-023 in_valid SHALL be ignored while in_ready=0; the upstream keeps in_data stable until it is accepted.

Reset
REQ-024 While rst=1 at a rising edge, the next state SHALL be occ_o=0, out_valid=0, out_data=RST_VAL; in_ready SHALL be 0 during reset.
REQ-025 Reset SHALL override flush_i, hold_i and any in-flight transfer, and the entries SHALL be discarded.
REQ-026 The first input transfer SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-027 The macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-028 With PIPE_STAGE_SKID_EN defined:
- the stage SHALL have two entries (output register plus skid register);
- in_ready SHALL be a registered signal equal to (occ_o<2) && !hold_i && !flush_i, with no combinational path from out_ready;
- occ_o SHALL reach 2 when out_ready drops while an input is accepted.
REQ-029 With PIPE_STAGE_SKID_EN undefined:
- the stage SHALL have one entry;
- in_ready SHALL be (!out_valid_reg || out_ready) && !hold_i && !flush_i, combinational;
- occ_o SHALL never exceed 1.

Verification
REQ-030 Reset: assert rst 2 cycles with in_valid=1 and in_data=32'hDEADBEEF -> out_valid=0, out_data=32'h0, occ_o=0; in_ready=1 in the first cycle after release.
REQ-031 Streaming: in_valid=1 with payloads 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 on cycles 1-4, no bubbles.
REQ-032 Backpressure (SKID_EN): out_ready=0 while 1,2,3 are offered -> 1 and 2 accepted, occ_o=2, in_ready=0, 3 is held; out_ready=1 -> outputs 1,2,3 in order.
REQ-033 Hold: hold_i=1 for 3 cycles while holding payload 5 -> out_valid=0, in_ready=0, occ_o unchanged; after release 5 is delivered once.
REQ-034 Flush with hold: occ_o=2, then flush_i=1 and hold_i=1 in the same cycle with in_valid=1 and in_data=9 -> next cycle occ_o=0, out_data=32'h00000013, and 9 is never output.
REQ-035 Non-skid build: occ_o=1 with out_ready=1 and in_valid=1 -> the input is accepted in the same cycle and occ_o stays 1 (in_ready follows out_ready combinationally).
